// File: rtl/axis_fringe_counter_pkg.sv
// Shared types and helpers for the fringe counter: comparator state encoding,
// quadrature step decode and the error counter width.
package axis_fringe_counter_pkg;

  localparam int ERR_COUNT_WIDTH = 16;

  typedef enum logic {
    CMP_LOW  = 1'b0,
    CMP_HIGH = 1'b1
  } cmp_state_t;

  // dir is 1 for a forward step, 0 for reverse; only meaningful with step=1
  typedef struct packed {
    logic error;
    logic dir;
    logic step;
  } quad_delta_t;

  // Position of a {b,a} code along the forward cycle 00 -> 01 -> 11 -> 10
  function automatic logic [1:0] quad_index(input logic [1:0] code);
    case (code)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // A modulo-4 index difference of 1 is forward, 3 is reverse, 2 means both bits moved
  function automatic quad_delta_t quad_delta(input logic [1:0] old_code,
                                             input logic [1:0] new_code);
    quad_delta_t d;
    logic [1:0]  diff;
    d    = '0;
    diff = quad_index(new_code) - quad_index(old_code);
    case (diff)
      2'd1: begin
        d.step = 1'b1;
        d.dir  = 1'b1;
      end
      2'd3:    d.step  = 1'b1;
      2'd2:    d.error = 1'b1;
      default: d       = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/axis_fringe_counter_comparator.sv
// Two-state hysteresis comparator that squares one signed channel; it only
// moves on enabled (accepted) samples and exposes its next state for decoding.
module hysteresis_comparator
  import axis_fringe_counter_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           enable,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic signed [SAMPLE_WIDTH-1:0] lower_threshold,
  input  logic signed [SAMPLE_WIDTH-1:0] upper_threshold,
  output logic                           high,
  output logic                           high_next
);

  cmp_state_t state_reg;
  cmp_state_t state_next;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg <= CMP_LOW;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strict comparisons: a sample equal to a threshold never switches
  always_comb begin
    state_next = state_reg;
    if (enable) begin
      case (state_reg)
        CMP_LOW:  if (sample > upper_threshold) state_next = CMP_HIGH;
        CMP_HIGH: if (sample < lower_threshold) state_next = CMP_LOW;
      endcase
    end
  end

  assign high      = (state_reg == CMP_HIGH);
  assign high_next = (state_next == CMP_HIGH);

endmodule

// File: rtl/axis_fringe_counter.sv
// Quadrature fringe counter: squares two channels with hysteresis, decodes the
// pair as quadrature and streams the signed position once per accepted sample.
module axis_fringe_counter
  import axis_fringe_counter_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
  input  logic                                clear,
  input  logic                                S_AXIS_tvalid,
  input  logic        [AXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
  output logic                                S_AXIS_tready,
  output logic                                M_AXIS_tvalid,
  output logic        [COUNT_WIDTH-1:0]       M_AXIS_tdata,
  input  logic                                M_AXIS_tready,
  output logic        [1:0]                   quad_state,
  output logic        [ERR_COUNT_WIDTH-1:0]   error_count
);

  localparam int CH_WIDTH = AXIS_TDATA_WIDTH / 2;

  logic                              accept;
  logic [1:0]                        cmp_high;
  logic [1:0]                        cmp_high_next;
  quad_delta_t                       delta;
  logic signed [COUNT_WIDTH-1:0]     position_reg;
  logic signed [COUNT_WIDTH-1:0]     position_next;
  logic [ERR_COUNT_WIDTH-1:0]        error_count_reg;
  logic [ERR_COUNT_WIDTH-1:0]        error_count_next;
  logic                              m_tvalid_reg;
  logic [COUNT_WIDTH-1:0]            m_tdata_reg;

  assign S_AXIS_tready = ~m_tvalid_reg | M_AXIS_tready;
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;

  // Channel 0 (a) is the low half of tdata, channel 1 (b) the high half
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_channel
      hysteresis_comparator #(
        .SAMPLE_WIDTH(CH_WIDTH)
      ) u_cmp (
        .aclk            (aclk),
        .areset          (areset),
        .enable          (accept),
        .sample          (S_AXIS_tdata[gi*CH_WIDTH +: CH_WIDTH]),
        .lower_threshold (lower_threshold),
        .upper_threshold (upper_threshold),
        .high            (cmp_high[gi]),
        .high_next       (cmp_high_next[gi])
      );
    end
  endgenerate

  // Clear wins over any step or error from a sample accepted alongside it
  always_comb begin
    delta            = quad_delta(cmp_high, cmp_high_next);
    position_next    = position_reg;
    error_count_next = error_count_reg;
    if (clear) begin
      position_next    = '0;
      error_count_next = '0;
    end else if (accept) begin
      if (delta.step) begin
        position_next = delta.dir ? position_reg + COUNT_WIDTH'(1)
                                  : position_reg - COUNT_WIDTH'(1);
      end
      if (delta.error && (error_count_reg != '1)) begin
        error_count_next = error_count_reg + ERR_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      position_reg    <= '0;
      error_count_reg <= '0;
      m_tvalid_reg    <= 1'b0;
      m_tdata_reg     <= '0;
    end else begin
      position_reg    <= position_next;
      error_count_reg <= error_count_next;
      if (accept) begin
        m_tvalid_reg <= 1'b1;
        m_tdata_reg  <= position_next;
      end else if (M_AXIS_tready) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

  assign M_AXIS_tvalid = m_tvalid_reg;
  assign M_AXIS_tdata  = m_tdata_reg;
  assign quad_state    = cmp_high;
  assign error_count   = error_count_reg;

endmodule

// File: tb/tb_axis_fringe_counter.sv
// Directed bench for axis_fringe_counter: a 32-bit and an 8-bit counter driven
// by the same stream, checked against hand-computed positions.
module tb_axis_fringe_counter;

  logic               aclk = 1'b0;
  logic               areset;
  logic               clear;
  logic               s_tvalid;
  logic [31:0]        s_tdata;
  logic               m_tready;
  logic signed [15:0] lower_thr;
  logic signed [15:0] upper_thr;

  logic        s_tready32, m_tvalid32;
  logic [31:0] m_tdata32;
  logic [1:0]  quad32;
  logic [15:0] err32;
  logic        s_tready8, m_tvalid8;
  logic [7:0]  m_tdata8;
  logic [1:0]  quad8;
  logic [15:0] err8;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_fringe_counter #(.AXIS_TDATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .lower_threshold(lower_thr), .upper_threshold(upper_thr),
    .clear(clear), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready32),
    .M_AXIS_tvalid(m_tvalid32), .M_AXIS_tdata(m_tdata32), .M_AXIS_tready(m_tready),
    .quad_state(quad32), .error_count(err32)
  );

  axis_fringe_counter #(.AXIS_TDATA_WIDTH(32), .COUNT_WIDTH(8)) dut8 (
    .aclk(aclk), .areset(areset), .lower_threshold(lower_thr), .upper_threshold(upper_thr),
    .clear(clear), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready8),
    .M_AXIS_tvalid(m_tvalid8), .M_AXIS_tdata(m_tdata8), .M_AXIS_tready(m_tready),
    .quad_state(quad8), .error_count(err8)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input longint pos, input longint quad, input longint err);
    check({tag, "_valid"}, longint'(m_tvalid32), 1);
    check({tag, "_pos"}, longint'($signed(m_tdata32)), pos);
    check({tag, "_quad"}, longint'(quad32), quad);
    check({tag, "_err"}, longint'(err32), err);
  endtask

  // One accepted sample per call; assumes downstream is ready
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input bit verbose);
    s_tvalid = 1'b1;
    s_tdata  = {b, a};
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    if (verbose)
      $display("sample a=%0d b=%0d -> tdata=%0d quad=%b err=%0d",
               a, b, $signed(m_tdata32), quad32, err32);
  endtask

  int fa[4] = '{200, 200, -200, -200};
  int fb[4] = '{0, 200, 200, -200};
  int fp[4] = '{1, 2, 3, 4};
  int fq[4] = '{1, 3, 2, 0};
  int ha[5] = '{200, 50, 100, -100, -101};
  int hp[5] = '{5, 5, 5, 5, 4};
  int hq[5] = '{1, 1, 1, 1, 0};
  int wa[4] = '{200, 200, -200, -200};
  int wb[4] = '{-200, 200, 200, -200};

  initial begin
    areset    = 1'b1;
    clear     = 1'b0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    m_tready  = 1'b1;
    lower_thr = -16'sd100;
    upper_thr = 16'sd100;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    check("rst_tready", longint'(s_tready32), 1);
    check("rst_tvalid", longint'(m_tvalid32), 0);
    check("rst_tdata", longint'($signed(m_tdata32)), 0);
    check("rst_quad", longint'(quad32), 0);
    check("rst_err", longint'(err32), 0);

    for (int i = 0; i < 3; i++) begin
      send(16'sd0, 16'sd0, 1'b1);
      beat($sformatf("zero%0d", i), 0, 0, 0);
    end

    for (int k = 0; k < 4; k++) begin
      send(16'(fa[k]), 16'(fb[k]), 1'b1);
      beat($sformatf("fwd%0d", k), fp[k], fq[k], 0);
    end

    for (int k = 0; k < 5; k++) begin
      send(16'(ha[k]), -16'sd200, 1'b1);
      beat($sformatf("hyst%0d", k), hp[k], hq[k], 0);
    end

    send(16'sd200, 16'sd200, 1'b1);
    beat("dbl1", 4, 3, 1);
    send(-16'sd200, -16'sd200, 1'b1);
    beat("dbl2", 4, 0, 2);

    // Backpressure with a beat pending
    send(16'sd200, -16'sd200, 1'b1);
    beat("bp_pre", 5, 1, 2);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {16'sd200, 16'sd200};
    #1 check("bp_tready_drop", longint'(s_tready32), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      check($sformatf("bp_hold%0d_tready", i), longint'(s_tready32), 0);
      beat($sformatf("bp_hold%0d", i), 5, 1, 2);
    end
    m_tready = 1'b1;
    #1 check("bp_release_tready", longint'(s_tready32), 1);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
    $display("sample a=200 b=200 (after stall) -> tdata=%0d quad=%b", $signed(m_tdata32), quad32);
    beat("bp_post", 6, 3, 2);
    send(-16'sd200, 16'sd200, 1'b1);
    beat("bp_next", 7, 2, 2);

    // Error saturation: alternate 01/10 so every sample is a double transition
    for (int i = 0; i < 65533; i++) begin
      if (i % 2 == 0) send(16'sd200, -16'sd200, 1'b0);
      else            send(-16'sd200, 16'sd200, 1'b0);
      if (i == 0) check("err_inc", longint'(err32), 3);
    end
    $display("after 65533 double transitions -> err=%0d", err32);
    beat("err_max", 7, 1, 65535);
    for (int i = 65533; i < 65540; i++) begin
      if (i % 2 == 0) send(16'sd200, -16'sd200, 1'b0);
      else            send(-16'sd200, 16'sd200, 1'b0);
    end
    $display("after 7 more double transitions -> err=%0d", err32);
    beat("err_sat", 7, 2, 65535);
    check("err_sat_pos8", longint'($signed(m_tdata8)), 7);

    // Clear coincident with a forward step (10 -> 00)
    clear = 1'b1;
    send(-16'sd200, -16'sd200, 1'b1);
    clear = 1'b0;
    beat("clear", 0, 0, 0);
    check("clear_pos8", longint'($signed(m_tdata8)), 0);

    // Wrap: 128 forward steps take the 8-bit counter from 127 to -128
    for (int c = 0; c < 32; c++) begin
      for (int k = 0; k < 4; k++) begin
        send(16'(wa[k]), 16'(wb[k]), 1'b0);
        if (c == 31 && k == 2) begin
          check("wrap_pre_pos8", longint'($signed(m_tdata8)), 127);
          check("wrap_pre_pos32", longint'($signed(m_tdata32)), 127);
        end
      end
    end
    $display("after 128 forward steps -> pos32=%0d pos8=%0d", $signed(m_tdata32), $signed(m_tdata8));
    check("wrap_pos8", longint'($signed(m_tdata8)), -128);
    beat("wrap", 128, 0, 0);
    send(-16'sd200, 16'sd200, 1'b1);
    check("unwrap_pos8", longint'($signed(m_tdata8)), 127);
    beat("unwrap", 127, 2, 0);

    // Asynchronous reset with a beat pending
    send(-16'sd200, -16'sd200, 1'b1);
    beat("pre_areset", 128, 0, 0);
    send(16'sd200, -16'sd200, 1'b1);
    #2 areset = 1'b1;
    #1;
    check("areset_tvalid", longint'(m_tvalid32), 0);
    check("areset_tdata", longint'($signed(m_tdata32)), 0);
    check("areset_quad", longint'(quad32), 0);
    check("areset_tready", longint'(s_tready32), 1);
    @(posedge aclk);
    #1 areset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fringe_counter.md
# axis_fringe_counter

Consumes the same two-channel sample stream as the extremum finder and its `lower_threshold`/`upper_threshold` outputs. Each 16-bit channel is squared by a hysteresis comparator, and the two square waves are decoded as quadrature. A signed fringe position counter is updated from the decoded steps and streamed downstream, one beat per input sample. Invalid double transitions are counted separately.

## Interface
- `AXIS_TDATA_WIDTH`, 32, input sample width; low half = channel a, high half = channel b, each signed.
- `COUNT_WIDTH`, 32, position counter / output tdata width.
- `aclk`  in  1  clock; all logic rising-edge.
- `areset`  in  1  reset, asynchronous and active-high.
- `lower_threshold`  in  AXIS_TDATA_WIDTH/2  signed; falling switch level.
- `upper_threshold`  in  AXIS_TDATA_WIDTH/2  signed; rising switch level.
- `clear`  in  1  synchronous; zeroes position and error count.
- `S_AXIS_tvalid`  in  1  input sample valid.
- `S_AXIS_tdata`  in  AXIS_TDATA_WIDTH  {b, a}.
- `S_AXIS_tready`  out  1  sample accepted when high with tvalid.
- `M_AXIS_tvalid`  out  1  position beat valid.
- `M_AXIS_tdata`  out  COUNT_WIDTH  signed position.
- `M_AXIS_tready`  in  1  downstream ready.
- `quad_state`  out  2  {b_high, a_high}, current comparator states.
- `error_count`  out  16  invalid-transition count, saturating.

## Operation
- A sample is accepted when `S_AXIS_tvalid & S_AXIS_tready`. Comparators, position and error count change only on accepted samples or on `clear`.
- Per-channel comparator FSM, states LOW and HIGH:
  - LOW→HIGH when sample > upper_threshold (signed, strict).
  - HIGH→LOW when sample < lower_threshold (signed, strict).
  - Otherwise hold; equality holds.
  - With lower > upper, the same per-state rules apply; no other priority exists.
- Quadrature decode compares old {b,a} with new {b,a}:
  - Forward sequence 00→01→11→10→00: position +1.
  - Reverse sequence: position −1.
  - No change: 0.
  - Both bits change: position 0, error_count +1, saturating at 0xFFFF.
- Position is signed COUNT_WIDTH and wraps two's-complement (max +1 → min, min −1 → max).
- `clear` asserted on a cycle:
  - Position and error_count become 0 at the next edge. Clear overrides any step or error from a sample accepted in the same cycle.
  - Comparator states still update from that sample.
  - The emitted beat carries 0.
- Output stage is a single register:
  - `S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready`.
  - On acceptance, M_AXIS_tvalid←1 and tdata←updated position.
  - Otherwise, if M_AXIS_tready, M_AXIS_tvalid←0.
  - tdata is held stable while tvalid & ~tready.

## Timing
- Reset values: comparators LOW (quad_state=00), position 0, M_AXIS_tvalid 0, M_AXIS_tdata 0, error_count 0. After reset, S_AXIS_tready=1 (combinational).
- Latency: sample accepted in cycle n → beat valid in cycle n+1 with the position including that sample. quad_state updates at the same edge.
- Throughput: one sample per cycle while M_AXIS_tready=1.
- Backpressure: a stall drops tready in the same cycle; no sample is lost or duplicated.
- Thresholds are sampled combinationally on the acceptance cycle. Changes take effect on the next accepted sample.
- areset mid-stream: immediate return to reset values. A pending beat is discarded.

## Structure
- Shared package:
  - Comparator state encoding (LOW=0, HIGH=1).
  - Quadrature step function `quad_delta(old, new)` returning {error, dir, step}.
  - Error counter width constant (16).
- One sub-module, `hysteresis_comparator`: signed sample, thresholds, enable (= accept), clk/reset, `high` output. Instantiated twice (a, b).
- Top holds the decode, counters and output register.

## Test plan
- Reset, then samples a=b=0, thresholds −100/+100, M_AXIS_tready=1 → beats all 0, quad_state=00, error_count=0.
- One forward cycle of a then b (a=+200; b=+200; a=−200; b=−200), tready=1 → tdata 1,2,3,4; quad_state 01,11,10,00.
- Hysteresis: a=+200, then a=+50, +100, −100 → state stays HIGH; then −101 → LOW, position −1 relative.
- From 00, a=b=+200 in one sample → position unchanged, error_count=1. After 0xFFFF errors, the count stays 0xFFFF.
- Backpressure: hold M_AXIS_tready=0 for 3 cycles with a beat pending → S_AXIS_tready=0, tdata stable. Release → next sample accepted, sequence contiguous.
- Wrap and clear: COUNT_WIDTH=8, preload to 127 via steps, one forward step → −128. `clear` coincident with a step → beat 0, quad_state updated.
